// File: rtl/spi_slave_pkt_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkt_if
// Description : Bundle of the SPI pins and RAM-side handshake signals used by
//               spi_slave_pkt.
//               slave  modport : the SPI slave's view (DUT side)
//               master modport : the SPI master / RAM view (driver side)
//   SS_n      master->slave  slave select, active-low
//   MOSI      master->slave  serial data in, MSB first
//   tx_data   RAM->slave     read data, DATA_W bits
//   tx_valid  RAM->slave     tx_data valid
//   MISO      slave->master  serial data out, MSB first
//   rx_data   slave->RAM     {cmd[1:0], payload}
//   rx_valid  slave->RAM     one-cycle strobe, rx_data complete
//   busy      slave->master  frame in progress
//   err       slave->master  one-cycle error strobe
//   err_code  slave->master  01 abort, 10 illegal read, 11 tx timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_pkt_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, busy, err, err_code
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, busy, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_pkt.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkt
// Description : SPI slave for the SPI->RAM path, single system clock.
//               MOSI is sampled every clk while SS_n is low and deserialised
//               into {cmd[1:0], payload}. Read-data frames (cmd 11 after a
//               cmd 10 address frame) stream RAM data back on MISO, MSB
//               first. Detects aborted frames, illegal reads and tx_valid
//               timeouts.
// Ports       : clk    - system clock, posedge
//               rst    - synchronous reset, active-high
//               io_spi - spi_slave_pkt_if.slave (SPI pins + RAM handshake)
// Parameters  : DATA_W     - payload bits per frame
//               TX_TIMEOUT - max cycles waiting for tx_valid, 0 = forever
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_pkt #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spi_slave_pkt_if.slave     io_spi
);

    localparam int c_WORD_W = DATA_W + 2;
    localparam int c_CNT_W  = $clog2(DATA_W + 2);
    localparam int c_TO_W   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_RX  = c_CNT_W'(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_TX  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LIMIT = c_TO_W'(TX_TIMEOUT);

    localparam logic [1:0] c_ERR_ABORT   = 2'b01;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] c_CMD_READ = 2'b11;
    localparam logic [1:0] c_CMD_ADDR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_WAIT_TX = 3'd2,
        S_TX      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic [c_WORD_W-2:0]   r_rx_sh;
    logic [DATA_W-1:0]     r_tx_sh;
    logic                  r_rd_addr;
    logic                  r_miso;
    logic [c_WORD_W-1:0]   r_rx_data;
    logic                  r_rx_valid;
    logic                  r_busy;
    logic                  r_err;
    logic [1:0]            r_err_code;

    // Word as it stands including the bit being sampled this edge; on the
    // final RX edge this is the complete frame.
    logic [c_WORD_W-1:0]   w_word;
    logic [1:0]            w_cmd;
    logic [c_TO_W-1:0]     w_to_next;

    assign w_word    = {r_rx_sh, io_spi.MOSI};
    assign w_cmd     = w_word[c_WORD_W-1 -: 2];
    assign w_to_next = r_to_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_rd_addr  <= 1'b0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;

            // Deselect wins over everything, including the final RX edge.
            // rd_addr is deliberately kept so an aborted read can be retried.
            if ((r_state != S_IDLE) && io_spi.SS_n) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_to_cnt <= '0;
                r_miso   <= 1'b0;
                if (r_state != S_DONE) begin
                    r_err      <= 1'b1;
                    r_err_code <= c_ERR_ABORT;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!io_spi.SS_n) begin
                            r_state <= S_RX;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end

                    S_RX: begin
                        r_rx_sh <= w_word[c_WORD_W-2:0];
                        if (r_cnt == c_LAST_RX) begin
                            r_rx_data <= w_word;
                            r_cnt     <= '0;
                            if (w_cmd == c_CMD_READ) begin
                                if (r_rd_addr) begin
                                    r_rx_valid <= 1'b1;
                                    r_to_cnt   <= '0;
                                    r_state    <= S_WAIT_TX;
                                end else begin
                                    // Read data requested with no address latched.
                                    r_err      <= 1'b1;
                                    r_err_code <= c_ERR_ILLEGAL;
                                    r_state    <= S_DONE;
                                end
                            end else begin
                                r_rx_valid <= 1'b1;
                                if (w_cmd == c_CMD_ADDR) begin
                                    r_rd_addr <= 1'b1;
                                end
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    S_WAIT_TX: begin
                        r_to_cnt <= w_to_next;
                        // tx_valid is checked first so it wins a tie with
                        // the timeout.
                        if (io_spi.tx_valid) begin
                            r_tx_sh <= io_spi.tx_data;
                            r_miso  <= io_spi.tx_data[DATA_W-1];
                            r_cnt   <= '0;
                            r_state <= S_TX;
                        end else if ((TX_TIMEOUT != 0) && (w_to_next == c_TO_LIMIT)) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_TIMEOUT;
                            r_state    <= S_DONE;
                        end
                    end

                    S_TX: begin
                        // r_cnt is the index of the bit currently on MISO.
                        if (r_cnt == c_LAST_TX) begin
                            r_miso    <= 1'b0;
                            r_rd_addr <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_miso  <= r_tx_sh[DATA_W-2];
                            r_tx_sh <= r_tx_sh << 1;
                        end
                    end

                    S_DONE: begin
                        r_miso <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_spi.MISO     = r_miso;
    assign io_spi.rx_data  = r_rx_data;
    assign io_spi.rx_valid = r_rx_valid;
    assign io_spi.busy     = r_busy;
    assign io_spi.err      = r_err;
    assign io_spi.err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_pkt.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_pkt
// Description : Scoreboard bench for spi_slave_pkt. Drivers push expected
//               rx_valid/err events (with their expected cycle) and expected
//               MISO bits into queues; monitors pop and compare whenever the
//               DUT presents an event. Two instances: DATA_W=8/TX_TIMEOUT=16
//               and DATA_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_pkt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_pkt_if #(.DATA_W(8))  ifa ();
    spi_slave_pkt_if #(.DATA_W(16)) ifb ();

    spi_slave_pkt #(.DATA_W(8),  .TX_TIMEOUT(16)) u_dut_a (.clk(clk), .rst(rst), .io_spi(ifa));
    spi_slave_pkt #(.DATA_W(16), .TX_TIMEOUT(32)) u_dut_b (.clk(clk), .rst(rst), .io_spi(ifb));

    typedef struct {
        bit          is_err;
        logic [17:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   ma[$];

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ifa.rx_valid || ifa.err) begin
                if (qa.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL a_unexpected: rx_valid=%0b err=%0b code=%0h, expected no event (cycle %0d)",
                             ifa.rx_valid, ifa.err, ifa.err_code, cyc);
                end else begin
                    e = qa.pop_front();
                    chk("a_kind",  {31'd0, ifa.err}, {31'd0, e.is_err});
                    chk("a_data",  ifa.err ? {30'd0, ifa.err_code} : {22'd0, ifa.rx_data}, {14'd0, e.data});
                    chk("a_cycle", cyc, e.cyc);
                end
            end
            if (ma.size() > 0) chk("a_miso", {31'd0, ifa.MISO}, {31'd0, ma.pop_front()});
            else               chk("a_miso_idle", {31'd0, ifa.MISO}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ifb.rx_valid || ifb.err) begin
                if (qb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL b_unexpected: rx_valid=%0b err=%0b, expected no event (cycle %0d)",
                             ifb.rx_valid, ifb.err, cyc);
                end else begin
                    e = qb.pop_front();
                    chk("b_kind",  {31'd0, ifb.err}, {31'd0, e.is_err});
                    chk("b_data",  ifb.err ? {30'd0, ifb.err_code} : {14'd0, ifb.rx_data}, {14'd0, e.data});
                    chk("b_cycle", cyc, e.cyc);
                end
            end
            chk("b_miso_idle", {31'd0, ifb.MISO}, 32'd0);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic push_a(input bit is_err, input logic [17:0] data, input int c);
        qa.push_back('{is_err, data, c});
    endtask

    // Selects the slave and presents nb bits of a wl-bit word, one per cycle.
    // Returns on the negedge after the edge that sampled the last bit.
    task automatic send_bits(input int d, input logic [17:0] w, input int wl, input int nb);
        if (d == 0) ifa.SS_n = 1'b0; else ifb.SS_n = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (d == 0) ifa.MOSI = w[wl-1-i]; else ifb.MOSI = w[wl-1-i];
        end
        @(negedge clk);
    endtask

    task automatic release_ss(input int d);
        if (d == 0) begin
            ifa.SS_n = 1'b1; ifa.MOSI = 1'b0;
        end else begin
            ifb.SS_n = 1'b1; ifb.MOSI = 1'b0;
        end
        @(negedge clk);
        if (d == 0) chk("a_busy_idle", {31'd0, ifa.busy}, 32'd0);
        else        chk("b_busy_idle", {31'd0, ifb.busy}, 32'd0);
    endtask

    // Full 10-bit frame on DUT A; event expected on the 10th RX edge.
    task automatic frame_a(input logic [9:0] w, input bit is_err, input logic [17:0] exp, input bit keep);
        push_a(is_err, exp, cyc + 11);
        send_bits(0, {8'd0, w}, 10, 10);
        chk("a_busy_frame", {31'd0, ifa.busy}, 32'd1);
        if (!keep) release_ss(0);
    endtask

    // Called on the negedge just after entering WAIT_TX. d<0: never send
    // tx_valid; otherwise tx_valid is sampled on the (d+1)th WAIT_TX edge.
    task automatic tx_phase(input int d, input logic [7:0] data);
        if (d < 0) begin
            push_a(1'b1, 18'h3, cyc + 16);
            repeat (20) @(negedge clk);
        end else begin
            repeat (d) @(negedge clk);
            ifa.tx_valid = 1'b1;
            ifa.tx_data  = data;
            @(posedge clk);
            for (int i = 7; i >= 0; i--) ma.push_back(data[i]);
            ma.push_back(1'b0);
            @(negedge clk);
            ifa.tx_valid = 1'b0;
            repeat (10) @(negedge clk);
        end
        release_ss(0);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_rx_valid"}, {31'd0, ifa.rx_valid}, 32'd0);
        chk({tag, "_err"},      {31'd0, ifa.err},      32'd0);
        chk({tag, "_err_code"}, {30'd0, ifa.err_code}, 32'd0);
        chk({tag, "_busy"},     {31'd0, ifa.busy},     32'd0);
        chk({tag, "_miso"},     {31'd0, ifa.MISO},     32'd0);
        chk({tag, "_rx_data"},  {22'd0, ifa.rx_data},  32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ifa.SS_n = 1'b1; ifa.MOSI = 1'b0; ifa.tx_valid = 1'b0; ifa.tx_data = '0;
        ifb.SS_n = 1'b1; ifb.MOSI = 1'b0; ifb.tx_valid = 1'b0; ifb.tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero_a("reset_a");
        chk("reset_b_busy",     {31'd0, ifb.busy},     32'd0);
        chk("reset_b_rx_data",  {14'd0, ifb.rx_data},  32'd0);
        chk("reset_b_err_code", {30'd0, ifb.err_code}, 32'd0);
        mon_en = 1'b1;

        // 1: plain write frames, 8- and 16-bit payloads
        frame_a(10'h0A5, 1'b0, 18'h0A5, 1'b0);
        qb.push_back('{1'b0, 18'h0A5C3, cyc + 19});
        send_bits(1, 18'h0A5C3, 18, 18);
        chk("b_busy_frame", {31'd0, ifb.busy}, 32'd1);
        release_ss(1);

        // 2: address frame, read frame with data, second read is illegal
        frame_a(10'h233, 1'b0, 18'h233, 1'b0);
        frame_a(10'h300, 1'b0, 18'h300, 1'b1);
        tx_phase(2, 8'hC3);
        frame_a(10'h300, 1'b1, 18'h2, 1'b0);

        // 3: read right after reset is illegal
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame_a(10'h3C5, 1'b1, 18'h2, 1'b0);

        // 4: abort after 5 bits, good frame, abort on the final-bit edge
        push_a(1'b1, 18'h1, cyc + 7);
        send_bits(0, 18'h3FF, 10, 5);
        release_ss(0);
        frame_a(10'h1F0, 1'b0, 18'h1F0, 1'b0);
        push_a(1'b1, 18'h1, cyc + 11);
        send_bits(0, 18'h155, 10, 9);
        release_ss(0);

        // 5: tx_valid timeout, then tx_valid on the timeout cycle itself
        frame_a(10'h201, 1'b0, 18'h201, 1'b0);
        frame_a(10'h300, 1'b0, 18'h300, 1'b1);
        tx_phase(-1, 8'h00);
        frame_a(10'h201, 1'b0, 18'h201, 1'b0);
        frame_a(10'h3FF, 1'b0, 18'h3FF, 1'b1);
        tx_phase(15, 8'h5A);

        // 6: reset in the middle of a MISO transfer
        frame_a(10'h244, 1'b0, 18'h244, 1'b0);
        frame_a(10'h300, 1'b0, 18'h300, 1'b1);
        ifa.tx_valid = 1'b1;
        ifa.tx_data  = 8'hC3;
        @(posedge clk);
        ma.push_back(1'b1); ma.push_back(1'b1); ma.push_back(1'b0); ma.push_back(1'b0);
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        ifa.SS_n = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_a("midtx_reset");
        frame_a(10'h300, 1'b1, 18'h2, 1'b0);

        repeat (5) @(negedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        chk("ma_drained", ma.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
